// File: rtl/buyruk_ffram_yazici.sv
// Packs a 32-bit little-endian byte stream into 41-bit instruction FF-RAM entries (5 bytes + bit 40).
// Optional BUYRUK_FFRAM_ESLIK_EN: bit 40 carries even parity of lane 4 instead of a constant 1.
module buyruk_ffram_yazici #(
    parameter int ADRES_BIT = 9,
    parameter int SAYI_BIT  = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 istek_gecerli_i,
    output logic                 istek_hazir_o,
    input  logic [ADRES_BIT-1:0] istek_adres_i,
    input  logic [SAYI_BIT-1:0]  istek_sayi_i,
    input  logic                 veri_gecerli_i,
    output logic                 veri_hazir_o,
    input  logic [31:0]          veri_i,
    output logic [4:0]           wen_o,
    output logic [40:0]          data_o,
    output logic [ADRES_BIT-1:0] wadr_o,
    output logic                 mesgul_o,
    output logic                 tamam_o
);

    localparam logic [1:0] BOS   = 2'd0;
    localparam logic [1:0] AKIS  = 2'd1;
    localparam logic [1:0] TASMA = 2'd2;

    logic [1:0]           durum_q;
    logic [ADRES_BIT-1:0] adres_q;
    logic [2:0]           b_q;
    logic [11:0]          kalan_q;
    logic [3:0]           tasma_wen_q;
    logic [31:0]          tasma_dat_q;

    logic [2:0]  n;
    logic [3:0]  serit_m;
    logic [31:0] veri_m;
    logic [71:0] kaydir;
    logic [8:0]  maske;
    logic [3:0]  son;
    logic        bit40;

    // Useful bytes of this beat; later bytes of a short final beat are dropped.
    always_comb begin
        n       = (kalan_q >= 12'd4) ? 3'd4 : kalan_q[2:0];
        serit_m = '0;
        veri_m  = '0;
        for (int k = 0; k < 4; k++) begin
            serit_m[k]      = (3'(k) < n);
            veri_m[8*k +: 8] = serit_m[k] ? veri_i[8*k +: 8] : 8'h00;
        end
        // Lanes 0..4 land in the current entry, anything above spills into the next one.
        kaydir = {40'd0, veri_m} << {b_q, 3'b000};
        maske  = {5'd0, serit_m} << b_q;
        son    = {1'b0, b_q} + {1'b0, n};
`ifdef BUYRUK_FFRAM_ESLIK_EN
        bit40  = maske[4] & (^kaydir[39:32]);
`else
        bit40  = maske[4];
`endif
    end

    assign istek_hazir_o = (durum_q == BOS);
    assign veri_hazir_o  = (durum_q == AKIS);
    assign mesgul_o      = (durum_q != BOS);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q     <= BOS;
            adres_q     <= '0;
            b_q         <= '0;
            kalan_q     <= '0;
            tasma_wen_q <= '0;
            tasma_dat_q <= '0;
            wen_o       <= '0;
            data_o      <= '0;
            wadr_o      <= '0;
            tamam_o     <= 1'b0;
        end else begin
            wen_o   <= '0;
            data_o  <= '0;
            tamam_o <= 1'b0;
            case (durum_q)
                BOS: begin
                    if (istek_gecerli_i) begin
                        adres_q <= istek_adres_i;
                        b_q     <= '0;
                        kalan_q <= 12'(istek_sayi_i) * 12'd5;
                        if (istek_sayi_i == '0) tamam_o <= 1'b1;
                        else                    durum_q <= AKIS;
                    end
                end
                AKIS: begin
                    // kalan=0 here means the last write is on the port this cycle.
                    if (kalan_q == 12'd0) begin
                        durum_q <= BOS;
                        tamam_o <= 1'b1;
                    end else if (veri_gecerli_i) begin
                        wen_o   <= maske[4:0];
                        data_o  <= {bit40, kaydir[39:0]};
                        wadr_o  <= adres_q;
                        kalan_q <= kalan_q - 12'(n);
                        if (son > 4'd5) begin
                            tasma_wen_q <= maske[8:5];
                            tasma_dat_q <= kaydir[71:40];
                            b_q         <= 3'(son - 4'd5);
                            durum_q     <= TASMA;
                        end else if (son == 4'd5) begin
                            b_q     <= '0;
                            adres_q <= adres_q + 1'b1;
                        end else begin
                            b_q <= son[2:0];
                        end
                    end
                end
                TASMA: begin
                    wen_o   <= {1'b0, tasma_wen_q};
                    data_o  <= {9'd0, tasma_dat_q};
                    wadr_o  <= adres_q + 1'b1;
                    adres_q <= adres_q + 1'b1;
                    durum_q <= AKIS;
                end
                default: durum_q <= BOS;
            endcase
        end
    end

endmodule

// File: tb/tb_buyruk_ffram_yazici.sv
// Directed bench for the FF-RAM fill engine: packing, spills, wrap, gaps, reset and bit-40 handling.
module tb_buyruk_ffram_yazici;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        istek_gecerli = 1'b0;
    logic        istek_hazir;
    logic [8:0]  istek_adres = '0;
    logic [9:0]  istek_sayi = '0;
    logic        veri_gecerli = 1'b0;
    logic        veri_hazir;
    logic [31:0] veri = '0;
    logic [4:0]  wen;
    logic [40:0] data;
    logic [8:0]  wadr;
    logic        mesgul;
    logic        tamam;

    int checks = 0;
    int errors = 0;

    buyruk_ffram_yazici #(.ADRES_BIT(9), .SAYI_BIT(10)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .istek_gecerli_i(istek_gecerli), .istek_hazir_o(istek_hazir),
        .istek_adres_i(istek_adres), .istek_sayi_i(istek_sayi),
        .veri_gecerli_i(veri_gecerli), .veri_hazir_o(veri_hazir), .veri_i(veri),
        .wen_o(wen), .data_o(data), .wadr_o(wadr),
        .mesgul_o(mesgul), .tamam_o(tamam)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write / handshake recorder, sampled mid-cycle.
    logic [4:0]  cap_wen [32];
    logic [40:0] cap_dat [32];
    logic [8:0]  cap_adr [32];
    int          cap_cyc [32];
    int          cap_n = 0;
    int          hs_c [16];
    int          hs_n = 0;
    int          tamam_n = 0;
    int          tamam_cyc = 0;
    int          low_n = 0;

    always @(negedge clk) begin
        if (wen != 5'd0 && cap_n < 32) begin
            cap_wen[cap_n] = wen;
            cap_dat[cap_n] = data;
            cap_adr[cap_n] = wadr;
            cap_cyc[cap_n] = cyc;
            cap_n++;
        end
        if (tamam) begin
            tamam_n++;
            tamam_cyc = cyc;
        end
        if (mesgul && !veri_hazir) low_n++;
        if (veri_gecerli && veri_hazir && hs_n < 16) begin
            hs_c[hs_n] = cyc;
            hs_n++;
        end
    end

    function automatic logic [40:0] exp_d(input logic [4:0] w, input logic [39:0] d);
        logic b40;
`ifdef BUYRUK_FFRAM_ESLIK_EN
        b40 = w[4] & (^d[39:32]);
`else
        b40 = w[4];
`endif
        return {b40, d};
    endfunction

    task automatic clr();
        cap_n = 0; hs_n = 0; tamam_n = 0; low_n = 0;
    endtask

    task automatic istek(input logic [8:0] a, input logic [9:0] s, output int bekle);
        logic acc;
        istek_adres = a; istek_sayi = s; istek_gecerli = 1'b1;
        bekle = 0;
        do begin
            @(negedge clk); acc = istek_hazir;
            @(posedge clk); bekle++;
        end while (!acc && bekle < 50);
        #1 istek_gecerli = 1'b0;
        if (!acc) begin
            errors++;
            $display("FAIL istek_timeout: no acceptance after %0d cycles, required acceptance", bekle);
        end
    endtask

    task automatic beat(input logic [31:0] d);
        logic acc;
        int   w = 0;
        veri = d; veri_gecerli = 1'b1;
        do begin
            @(negedge clk); acc = veri_hazir;
            @(posedge clk); w++;
        end while (!acc && w < 50);
        #1 veri_gecerli = 1'b0;
        if (!acc) begin
            errors++;
            $display("FAIL beat_timeout: beat %h not taken in %0d cycles", d, w);
        end
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({wen, data, wadr, veri_hazir, tamam, mesgul, istek_hazir} !== {5'd0, 41'd0, 9'd0, 4'b0001}) begin
            errors++;
            $display("FAIL reset_values: got wen=%b data=%h wadr=%h vh=%b tm=%b ms=%b ih=%b",
                     wen, data, wadr, veri_hazir, tamam, mesgul, istek_hazir);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int bk;
        clr();
        istek(9'h010, 10'd1, bk);
        beat(32'h44332211);
        beat(32'h88776655);
        settle();
        checks++;
        if (cap_n !== 2) begin errors++; $display("FAIL single_count: got %0d writes, required 2", cap_n); end
        if (cap_n >= 2) begin
            checks++;
            if ({cap_wen[0], cap_adr[0], cap_dat[0]} !== {5'b01111, 9'h010, 41'h0_00_44332211}) begin
                errors++; $display("FAIL single_w0: got %b@%h %h", cap_wen[0], cap_adr[0], cap_dat[0]);
            end
            checks++;
            if ({cap_wen[1], cap_adr[1], cap_dat[1]} !== {5'b10000, 9'h010, exp_d(5'b10000, 40'h55_00000000)}) begin
                errors++; $display("FAIL single_w1: got %b@%h %h", cap_wen[1], cap_adr[1], cap_dat[1]);
            end
            checks++;
            if (cap_cyc[0] !== hs_c[0] + 1) begin
                errors++; $display("FAIL single_latency: write cycle %0d, required %0d", cap_cyc[0], hs_c[0] + 1);
            end
            checks++;
            if (tamam_n !== 1 || tamam_cyc !== cap_cyc[1] + 1) begin
                errors++; $display("FAIL single_tamam: %0d pulses at %0d, required 1 at %0d", tamam_n, tamam_cyc, cap_cyc[1] + 1);
            end
        end
    endtask

    task automatic test_burst(input bit gap);
        logic [4:0]  e_wen [8] = '{5'b01111, 5'b10000, 5'b00111, 5'b11000, 5'b00011, 5'b11100, 5'b00001, 5'b11110};
        logic [8:0]  e_adr [8] = '{9'd0, 9'd0, 9'd1, 9'd1, 9'd2, 9'd2, 9'd3, 9'd3};
        logic [39:0] e_dat [8] = '{40'h00_03020100, 40'h04_00000000, 40'h00_00070605, 40'h09_08000000,
                                   40'h00_00000B0A, 40'h0E_0D0C0000, 40'h00_0000000F, 40'h13_12111000};
        int          e_bt  [8] = '{0, 1, 1, 2, 2, 3, 3, 4};
        int          e_sp  [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
        logic [31:0] bt    [5] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 32'h13121110};
        int bk;
        clr();
        istek(9'h000, 10'd4, bk);
        for (int i = 0; i < 5; i++) begin
            beat(bt[i]);
            if (gap) begin @(posedge clk); #1; end
        end
        settle();
        checks++;
        if (cap_n !== 8 || hs_n !== 5) begin
            errors++; $display("FAIL burst%0d_count: %0d writes %0d beats, required 8 and 5", gap, cap_n, hs_n);
        end
        if (cap_n >= 8 && hs_n >= 5) begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if ({cap_wen[i], cap_adr[i], cap_dat[i]} !== {e_wen[i], e_adr[i], exp_d(e_wen[i], e_dat[i])}) begin
                    errors++; $display("FAIL burst%0d_w%0d: got %b@%h %h, required %b@%h %h", gap, i,
                                       cap_wen[i], cap_adr[i], cap_dat[i], e_wen[i], e_adr[i], exp_d(e_wen[i], e_dat[i]));
                end
                checks++;
                if (cap_cyc[i] !== hs_c[e_bt[i]] + 1 + e_sp[i]) begin
                    errors++; $display("FAIL burst%0d_cyc%0d: got %0d, required %0d", gap, i, cap_cyc[i], hs_c[e_bt[i]] + 1 + e_sp[i]);
                end
            end
        end
        checks++;
        if (low_n !== 3) begin errors++; $display("FAIL burst%0d_hazir_low: got %0d, required 3", gap, low_n); end
        checks++;
        if (tamam_n !== 1) begin errors++; $display("FAIL burst%0d_tamam: got %0d pulses, required 1", gap, tamam_n); end
    endtask

    task automatic test_wrap();
        logic [4:0]  e_wen [4] = '{5'b01111, 5'b10000, 5'b00111, 5'b11000};
        logic [8:0]  e_adr [4] = '{9'h1FF, 9'h1FF, 9'h000, 9'h000};
        logic [39:0] e_dat [4] = '{40'h00_A3A2A1A0, 40'hB0_00000000, 40'h00_00B3B2B1, 40'hC1_C0000000};
        int bk;
        clr();
        istek(9'h1FF, 10'd2, bk);
        beat(32'hA3A2A1A0);
        beat(32'hB3B2B1B0);
        beat(32'hC3C2C1C0);
        settle();
        checks++;
        if (cap_n !== 4) begin errors++; $display("FAIL wrap_count: got %0d writes, required 4", cap_n); end
        if (cap_n >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({cap_wen[i], cap_adr[i], cap_dat[i]} !== {e_wen[i], e_adr[i], exp_d(e_wen[i], e_dat[i])}) begin
                    errors++; $display("FAIL wrap_w%0d: got %b@%h %h", i, cap_wen[i], cap_adr[i], cap_dat[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int bk;
        clr();
        istek(9'h000, 10'd4, bk);
        beat(32'h03020100);
        beat(32'h07060504);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({wen, data, wadr, veri_hazir, tamam, mesgul, istek_hazir} !== {5'd0, 41'd0, 9'd0, 4'b0001}) begin
            errors++;
            $display("FAIL midreset_values: got wen=%b data=%h wadr=%h vh=%b tm=%b ms=%b ih=%b",
                     wen, data, wadr, veri_hazir, tamam, mesgul, istek_hazir);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cap_n !== 2 || tamam_n !== 0) begin
            errors++; $display("FAIL midreset_nowrite: got %0d writes %0d tamam, required 2 and 0", cap_n, tamam_n);
        end
        istek(9'h005, 10'd1, bk);
        checks++;
        if (bk !== 1) begin errors++; $display("FAIL midreset_accept: took %0d cycles, required 1", bk); end
        @(negedge clk);
        checks++;
        if (mesgul !== 1'b1) begin errors++; $display("FAIL midreset_busy: got %b, required 1", mesgul); end
        @(posedge clk); #1;
        beat(32'h11111111);
        beat(32'h00000022);
        settle();
        checks++;
        if (cap_n !== 4 || cap_adr[2] !== 9'h005 || cap_wen[2] !== 5'b01111) begin
            errors++; $display("FAIL midreset_new: got %0d writes, w2 %b@%h", cap_n, cap_wen[2], cap_adr[2]);
        end
    endtask

    task automatic test_lane4_bit();
        int   bk;
        logic e40;
`ifdef BUYRUK_FFRAM_ESLIK_EN
        e40 = 1'b0;
`else
        e40 = 1'b1;
`endif
        clr();
        istek(9'h020, 10'd1, bk);
        beat(32'hDDCCBBAA);
        beat(32'hEEEEEE03);
        settle();
        checks++;
        if (cap_n !== 2) begin errors++; $display("FAIL lane4_count: got %0d, required 2", cap_n); end
        if (cap_n >= 2) begin
            checks++;
            if (cap_dat[1] !== {e40, 8'h03, 32'h0} || cap_wen[1] !== 5'b10000) begin
                errors++; $display("FAIL lane4_bit40: got %b %h, required 10000 %h", cap_wen[1], cap_dat[1], {e40, 8'h03, 32'h0});
            end
            checks++;
            if (cap_dat[0][40] !== 1'b0) begin errors++; $display("FAIL lane4_off_bit40: got %b, required 0", cap_dat[0][40]); end
        end
    endtask

    task automatic test_sayi_zero();
        int bk;
        clr();
        istek(9'h033, 10'd0, bk);
        @(negedge clk);
        checks++;
        if ({tamam, mesgul, istek_hazir} !== 3'b101) begin
            errors++; $display("FAIL zero_tamam: got tm=%b ms=%b ih=%b, required 1 0 1", tamam, mesgul, istek_hazir);
        end
        @(negedge clk);
        checks++;
        if (tamam !== 1'b0) begin errors++; $display("FAIL zero_pulse_width: got %b, required 0", tamam); end
        settle();
        checks++;
        if (cap_n !== 0 || tamam_n !== 1) begin
            errors++; $display("FAIL zero_writes: got %0d writes %0d tamam, required 0 and 1", cap_n, tamam_n);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst(1'b0);
        test_burst(1'b1);
        test_wrap();
        test_reset_mid();
        test_lane4_bit();
        test_sayi_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buyruk_ffram_yazici.md
# buyruk_ffram_yazici

Fill engine that writes the 41-bit instruction flip-flop RAM from a 32-bit little-endian memory data stream. It packs incoming bytes into 5-byte RAM entries, drives the RAM write port (byte-lane enables, data, address), and sets bit 40 of each entry when its lane 4 is written. It sits between the instruction-cache refill path and the RAM write port.

## Interface
- `ADRES_BIT`, 9: RAM entry address width (512 entries).
- `SAYI_BIT`, 10: entry-count width (0..512).
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `istek_gecerli_i`  in  1  fill request valid.
- `istek_hazir_o`  out  1  engine idle and accepts a request.
- `istek_adres_i`  in  9  first entry address.
- `istek_sayi_i`  in  10  number of entries to fill.
- `veri_gecerli_i`  in  1  data beat valid.
- `veri_hazir_o`  out  1  engine accepts a beat.
- `veri_i`  in  32  data beat; byte 0 = `[7:0]` is the earliest byte.
- `wen_o`  out  5  RAM lane enables; lane k = `data_o[8k+7:8k]`, lane 4 also covers `data_o[40]`.
- `data_o`  out  41  RAM write data.
- `wadr_o`  out  9  RAM write address.
- `mesgul_o`  out  1  transfer in progress.
- `tamam_o`  out  1  one-cycle transfer-complete pulse.

## Operation
- States: BOS (idle), AKIS (streaming), TASMA (spill write).
- BOS: `istek_hazir_o`=1, `veri_hazir_o`=0. Handshake `istek_gecerli_i & istek_hazir_o` latches the address, sets lane pointer b=0 and remaining bytes kalan=5*sayi (12 bits), then goes to AKIS.
- sayi=0: accepted, no writes, `tamam_o` next cycle, stays BOS.
- AKIS: `veri_hazir_o`=1. Each beat carries n=min(4,kalan) useful bytes; bytes past n are discarded. kalan -= n.
  - b+n ≤ 5: one write, lanes b..b+n-1 at current address. b becomes b+n; if b reaches 5, b=0 and the address increments.
  - b+n > 5: first write covers lanes b..4 at the current address. Go to TASMA; the remaining b+n-5 bytes go to lanes 0.. at address+1.
- TASMA: `veri_hazir_o`=0. Issue the spill write. Address increments, b = spill byte count. Return to AKIS, or finish if kalan=0.
- Finish: after the final write, go to BOS. `tamam_o` pulses in the cycle the engine returns to BOS.
- Bytes map to lanes in stream order. In every write, `data_o` lanes not enabled are 0.
- Address arithmetic is modulo 512 (0x1FF+1 = 0x000).
- `mesgul_o` = state ≠ BOS.
- Beats offered while in BOS are not accepted.

## Timing
- Write outputs are registered.
  - Beat handshaked in cycle t: its write is on `wen_o`/`data_o`/`wadr_o` in cycle t+1.
  - If the beat spills, the spill write is in cycle t+2 and `veri_hazir_o`=0 in cycle t+1.
- The RAM commits at the rising edge that ends each write cycle.
- Non-spilling beats are accepted back-to-back at 1 beat/cycle.
- `wen_o`=0 in every cycle without a write.
- `tamam_o` is high in the cycle after the final write cycle.
- Reset values: `wen_o`=0, `data_o`=0, `wadr_o`=0, `veri_hazir_o`=0, `tamam_o`=0, `mesgul_o`=0, `istek_hazir_o`=1; state BOS.
- Reset mid-transfer abandons the transfer immediately. No further writes; already-written entries remain.

## Configuration
- `BUYRUK_FFRAM_ESLIK_EN` defined: `data_o[40]` = even-parity bit `^data_o[39:32]` on every lane-4 write.
- Not defined: `data_o[40]`=1 on every lane-4 write (entry-complete marker).
- In both cases `data_o[40]`=0 when lane 4 is not enabled.

## Test plan
- adres=0x010, sayi=1, beats 0x44332211, 0x88776655:
  - write wadr 0x010, wen 01111, data[31:0] 0x44332211;
  - then wadr 0x010, wen 10000, data[39:32] 0x55, bit40=1 (macro off);
  - 0x66..0x88 not written; one `tamam_o` pulse.
- adres=0, sayi=4, five back-to-back beats produce 8 writes, in this wen/wadr sequence:
  - 01111@0;
  - 10000@0, 00111@1;
  - 11000@1, 00011@2;
  - 11100@2, 00001@3;
  - 11110@3;
  - `veri_hazir_o` low exactly 3 cycles.
- adres=0x1FF, sayi=2: entry 0 written at 0x1FF, entry 1 at 0x000.
- Same as scenario 2 with `veri_gecerli_i` idle every other cycle: identical write sequence; no write in idle cycles.
- Assert `rst_ni` after the second beat of scenario 2: all outputs at reset values, no further writes; a new request is accepted on the first cycle after release.
- Lane-4 byte 0x03:
  - with `BUYRUK_FFRAM_ESLIK_EN`, bit40=0;
  - without, bit40=1;
  - a request with sayi=0 produces `tamam_o` one cycle after acceptance and no writes.
